ahb_mst_mux: RTL and testbench

Parametrised AHB master-side multiplexer for the system bus, the successor to the fixed 16-master write mux. Routes the address/control phase of the master selected by the arbiter's HMASTER, tracks the owner of the pipelined data phase to select HWDATA and route HRESP back to the correct master, and flags illegal master indices. Sits between the arbiter/masters and the AHB decoder/slave side.

---
 rtl/ahb_mst_mux.sv | 148 ++++++++++++++
 tb/tb_ahb_mst_mux.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ahb_mst_mux.sv
// AHB master-side multiplexer: routes the arbiter-selected master's address phase and tracks the data-phase owner.
// Optional per-master completed-transfer counters are built when AHB_MUX_TRANS_CNT_EN is defined.
`ifndef AHB_BUS_WIDTH
`define AHB_BUS_WIDTH 32
`endif

module ahb_mst_mux #(
    parameter int NUM_MST = 4,
    parameter int AW      = 32,
    parameter int DW      = `AHB_BUS_WIDTH
) (
    input  logic                  HCLK,
    input  logic                  HRST,
    input  logic [NUM_MST*AW-1:0] HADDR_i,
    input  logic [NUM_MST*DW-1:0] HWDATA_i,
    input  logic [NUM_MST*2-1:0]  HTRANS_i,
    input  logic [NUM_MST*3-1:0]  HSIZE_i,
    input  logic [NUM_MST*3-1:0]  HBURST_i,
    input  logic [NUM_MST*4-1:0]  HPROT_i,
    input  logic [NUM_MST-1:0]    HWRITE_i,
    input  logic [3:0]            HMASTER_i,
    input  logic                  HREADY_i,
    input  logic                  HRESP_i,
    output logic [AW-1:0]         HADDR_o,
    output logic [DW-1:0]         HWDATA_o,
    output logic [1:0]            HTRANS_o,
    output logic [2:0]            HSIZE_o,
    output logic [2:0]            HBURST_o,
    output logic [3:0]            HPROT_o,
    output logic                  HWRITE_o,
    output logic [NUM_MST-1:0]    HRESP_o,
    output logic                  DP_VLD_o,
    output logic [3:0]            DP_MST_o,
    output logic                  MST_ERR_o,
    input  logic                  CNT_CLR_i,
    output logic [NUM_MST*16-1:0] CNT_o
);

    localparam logic [4:0] NUM_MST_W = 5'(NUM_MST);

    // All 16 HMASTER codes get a slot; unused slots read as zero, which yields IDLE and zero controls.
    logic [AW-1:0] w_addr  [16];
    logic [DW-1:0] w_wdata [16];
    logic [1:0]    w_trans [16];
    logic [2:0]    w_size  [16];
    logic [2:0]    w_burst [16];
    logic [3:0]    w_prot  [16];
    logic          w_write [16];
    logic          w_sel_bad;

    logic [3:0]    r_dp_mst;
    logic          r_dp_vld;
    logic          r_dp_bad;
    logic          r_mst_err;

    genvar g;
    for (g = 0; g < 16; g++) begin : g_slot
        if (g < NUM_MST) begin : g_used
            assign w_addr[g]  = HADDR_i[g*AW +: AW];
            assign w_wdata[g] = HWDATA_i[g*DW +: DW];
            assign w_trans[g] = HTRANS_i[g*2 +: 2];
            assign w_size[g]  = HSIZE_i[g*3 +: 3];
            assign w_burst[g] = HBURST_i[g*3 +: 3];
            assign w_prot[g]  = HPROT_i[g*4 +: 4];
            assign w_write[g] = HWRITE_i[g];
        end else begin : g_empty
            assign w_addr[g]  = '0;
            assign w_wdata[g] = '0;
            assign w_trans[g] = 2'b00;
            assign w_size[g]  = 3'b000;
            assign w_burst[g] = 3'b000;
            assign w_prot[g]  = 4'b0000;
            assign w_write[g] = 1'b0;
        end
    end

    assign w_sel_bad = ({1'b0, HMASTER_i} >= NUM_MST_W);

    assign HADDR_o  = w_addr[HMASTER_i];
    assign HTRANS_o = w_trans[HMASTER_i];
    assign HSIZE_o  = w_size[HMASTER_i];
    assign HBURST_o = w_burst[HMASTER_i];
    assign HPROT_o  = w_prot[HMASTER_i];
    assign HWRITE_o = w_write[HMASTER_i];

    // Data-phase owner tracking; holds through wait states.
    always_ff @(posedge HCLK) begin
        if (HRST) begin
            r_dp_mst  <= 4'd0;
            r_dp_vld  <= 1'b0;
            r_dp_bad  <= 1'b0;
            r_mst_err <= 1'b0;
        end else if (HREADY_i) begin
            r_dp_mst <= HMASTER_i;
            r_dp_vld <= w_trans[HMASTER_i][1];
            r_dp_bad <= w_sel_bad;
            if (w_sel_bad) begin
                r_mst_err <= 1'b1;
            end
        end
    end

    // Write data follows the data-phase owner; a bad owner drives zero.
    always_comb begin
        if (r_dp_bad) begin
            HWDATA_o = '0;
        end else begin
            HWDATA_o = w_wdata[r_dp_mst];
        end
    end

    for (g = 0; g < NUM_MST; g++) begin : g_resp
        assign HRESP_o[g] = HRESP_i & r_dp_vld & (r_dp_mst == 4'(g));
    end

    assign DP_VLD_o  = r_dp_vld;
    assign DP_MST_o  = r_dp_mst;
    assign MST_ERR_o = r_mst_err;

`ifdef AHB_MUX_TRANS_CNT_EN
    logic [15:0] r_cnt [NUM_MST];

    // Saturating completed-transfer counters; clear wins over increment.
    always_ff @(posedge HCLK) begin
        if (HRST || CNT_CLR_i) begin
            for (int m = 0; m < NUM_MST; m++) begin
                r_cnt[m] <= 16'd0;
            end
        end else begin
            for (int m = 0; m < NUM_MST; m++) begin
                if (r_dp_vld && !r_dp_bad && HREADY_i && (r_dp_mst == 4'(m))
                    && (r_cnt[m] != 16'hFFFF)) begin
                    r_cnt[m] <= r_cnt[m] + 16'd1;
                end
            end
        end
    end

    for (g = 0; g < NUM_MST; g++) begin : g_cnt
        assign CNT_o[g*16 +: 16] = r_cnt[g];
    end
`else
    logic w_cnt_clr_unused;
    assign w_cnt_clr_unused = CNT_CLR_i;
    assign CNT_o = '0;
`endif

endmodule

// File: tb/tb_ahb_mst_mux.sv
// Scoreboard bench for ahb_mst_mux: driver pushes model predictions, monitor pops and compares.
`timescale 1ns/1ps
module tb_ahb_mst_mux;
    localparam int NM = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    logic HRST;
    logic [NM*AW-1:0] HADDR_i;
    logic [NM*DW-1:0] HWDATA_i;
    logic [NM*2-1:0]  HTRANS_i;
    logic [NM*3-1:0]  HSIZE_i, HBURST_i;
    logic [NM*4-1:0]  HPROT_i;
    logic [NM-1:0]    HWRITE_i;
    logic [3:0]       HMASTER_i;
    logic             HREADY_i, HRESP_i, CNT_CLR_i;
    logic [AW-1:0]    HADDR_o;
    logic [DW-1:0]    HWDATA_o;
    logic [1:0]       HTRANS_o;
    logic [2:0]       HSIZE_o, HBURST_o;
    logic [3:0]       HPROT_o;
    logic             HWRITE_o;
    logic [NM-1:0]    HRESP_o;
    logic             DP_VLD_o;
    logic [3:0]       DP_MST_o;
    logic             MST_ERR_o;
    logic [NM*16-1:0] CNT_o;

    ahb_mst_mux #(.NUM_MST(NM), .AW(AW), .DW(DW)) dut (
        .HCLK(HCLK), .HRST(HRST),
        .HADDR_i(HADDR_i), .HWDATA_i(HWDATA_i), .HTRANS_i(HTRANS_i),
        .HSIZE_i(HSIZE_i), .HBURST_i(HBURST_i), .HPROT_i(HPROT_i), .HWRITE_i(HWRITE_i),
        .HMASTER_i(HMASTER_i), .HREADY_i(HREADY_i), .HRESP_i(HRESP_i),
        .HADDR_o(HADDR_o), .HWDATA_o(HWDATA_o), .HTRANS_o(HTRANS_o),
        .HSIZE_o(HSIZE_o), .HBURST_o(HBURST_o), .HPROT_o(HPROT_o), .HWRITE_o(HWRITE_o),
        .HRESP_o(HRESP_o), .DP_VLD_o(DP_VLD_o), .DP_MST_o(DP_MST_o), .MST_ERR_o(MST_ERR_o),
        .CNT_CLR_i(CNT_CLR_i), .CNT_o(CNT_o)
    );

    // per-master stimulus
    logic [31:0] s_addr [NM];
    logic [31:0] s_wdata[NM];
    logic [1:0]  s_trans[NM];
    logic [2:0]  s_size [NM];
    logic [2:0]  s_burst[NM];
    logic [3:0]  s_prot [NM];
    logic        s_write[NM];
    logic [3:0]  s_hm;
    logic        s_rdy, s_resp, s_clr, s_rst;

    // reference model state
    int m_own;
    bit m_vld, m_bad, m_err;
    int m_cnt[NM];

    typedef struct {
        logic [31:0] addr; logic [1:0] trans; logic [2:0] size; logic [2:0] burst;
        logic [3:0] prot; logic wr; logic [31:0] wdata; logic [3:0] resp;
        logic dvld; logic [3:0] dmst; logic err; logic [63:0] cnt;
    } exp_t;
    exp_t q[$];
    exp_t e;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        exp_t x;
        bit ok;
        @(negedge HCLK);
        HRST = s_rst; HMASTER_i = s_hm; HREADY_i = s_rdy; HRESP_i = s_resp; CNT_CLR_i = s_clr;
        for (int m = 0; m < NM; m++) begin
            HADDR_i[m*AW +: AW] = s_addr[m];  HWDATA_i[m*DW +: DW] = s_wdata[m];
            HTRANS_i[m*2 +: 2]  = s_trans[m]; HSIZE_i[m*3 +: 3]    = s_size[m];
            HBURST_i[m*3 +: 3]  = s_burst[m]; HPROT_i[m*4 +: 4]    = s_prot[m];
            HWRITE_i[m]         = s_write[m];
        end
        ok = (int'(s_hm) < NM);
        x.addr  = ok ? s_addr[s_hm]  : 32'd0;
        x.trans = ok ? s_trans[s_hm] : 2'b00;
        x.size  = ok ? s_size[s_hm]  : 3'd0;
        x.burst = ok ? s_burst[s_hm] : 3'd0;
        x.prot  = ok ? s_prot[s_hm]  : 4'd0;
        x.wr    = ok ? s_write[s_hm] : 1'b0;
        x.wdata = m_bad ? 32'd0 : s_wdata[m_own];
        x.resp  = 4'd0;
        if (m_vld && m_own < NM) x.resp[m_own] = s_resp;
        x.dvld = m_vld;
        x.dmst = 4'(m_own);
        x.err  = m_err;
        x.cnt  = 64'd0;
`ifdef AHB_MUX_TRANS_CNT_EN
        for (int m = 0; m < NM; m++) x.cnt[m*16 +: 16] = 16'(m_cnt[m]);
`endif
        q.push_back(x);
        // advance model across the coming edge
        if (s_rst) begin
            m_own = 0; m_vld = 0; m_bad = 0; m_err = 0;
            for (int m = 0; m < NM; m++) m_cnt[m] = 0;
        end else begin
            for (int m = 0; m < NM; m++) begin
                if (s_clr) m_cnt[m] = 0;
                else if (m_vld && !m_bad && s_rdy && m_own == m && m_cnt[m] < 65535) m_cnt[m]++;
            end
            if (s_rdy) begin
                m_own = int'(s_hm);
                m_vld = ok && s_trans[s_hm][1];
                m_bad = !ok;
                if (!ok) m_err = 1;
            end
        end
    endtask

    // monitor: pops one prediction per cycle once inputs have settled
    always @(negedge HCLK) begin
        #2;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("haddr",  64'(HADDR_o),  64'(e.addr));
            chk("htrans", 64'(HTRANS_o), 64'(e.trans));
            chk("hsize",  64'(HSIZE_o),  64'(e.size));
            chk("hburst", 64'(HBURST_o), 64'(e.burst));
            chk("hprot",  64'(HPROT_o),  64'(e.prot));
            chk("hwrite", 64'(HWRITE_o), 64'(e.wr));
            chk("hwdata", 64'(HWDATA_o), 64'(e.wdata));
            chk("hresp",  64'(HRESP_o),  64'(e.resp));
            chk("dp_vld", 64'(DP_VLD_o), 64'(e.dvld));
            chk("dp_mst", 64'(DP_MST_o), 64'(e.dmst));
            chk("mst_err",64'(MST_ERR_o),64'(e.err));
            chk("cnt",    CNT_o,         e.cnt);
        end
    end

    task automatic rand_masters();
        for (int m = 0; m < NM; m++) begin
            s_addr[m] = $urandom; s_wdata[m] = $urandom; s_trans[m] = 2'($urandom_range(0, 3));
            s_size[m] = 3'($urandom_range(0, 7)); s_burst[m] = 3'($urandom_range(0, 7));
            s_prot[m] = 4'($urandom_range(0, 15)); s_write[m] = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic quiet();
        rand_masters();
        s_rst = 0; s_clr = 0; s_resp = 0; s_rdy = 1; s_hm = 4'd0;
        for (int m = 0; m < NM; m++) s_trans[m] = 2'b00;
    endtask

    initial begin
        m_own = 0; m_vld = 0; m_bad = 0; m_err = 0;
        for (int m = 0; m < NM; m++) m_cnt[m] = 0;
        quiet(); s_rst = 1;
        step(); step();
        // reset state, then master 2 NONSEQ write to 0x8000_0010
        quiet(); step();
        s_hm = 4'd2; s_addr[2] = 32'h8000_0010; s_trans[2] = 2'b10; s_write[2] = 1'b1;
        step();
        s_hm = 4'd0; s_trans[2] = 2'b00; step();
        // master 1 then master 3 with three wait states in master 1's data phase
        s_hm = 4'd1; s_trans[1] = 2'b10; step();
        s_hm = 4'd3; s_trans[3] = 2'b10; s_trans[1] = 2'b00; s_rdy = 0;
        step(); step(); step();
        s_rdy = 1; step();
        s_hm = 4'd0; s_trans[3] = 2'b00; step(); step();
        // two-cycle ERROR in master 0's data phase
        s_hm = 4'd0; s_trans[0] = 2'b10; step();
        s_trans[0] = 2'b00; s_resp = 1; s_rdy = 0; step();
        s_rdy = 1; step();
        s_resp = 0; step();
        // out-of-range master, sticky error
        s_hm = 4'hF; step();
        s_hm = 4'd0; step(); step();
        // reset during a waited data phase
        s_hm = 4'd2; s_trans[2] = 2'b11; step();
        s_rdy = 0; s_resp = 1; step();
        s_rst = 1; step();
        s_rst = 0; step(); step();
        quiet(); step();
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rand_masters();
            s_hm   = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
            s_rdy  = ($urandom_range(0, 3) != 0);
            s_resp = 1'($urandom_range(0, 1));
            s_clr  = ($urandom_range(0, 49) == 0);
            s_rst  = ($urandom_range(0, 199) == 0);
            step();
        end
        quiet(); step();
`ifdef AHB_MUX_TRANS_CNT_EN
        // saturate master 1's counter, then clear in a completing cycle
        s_hm = 4'd1; s_trans[1] = 2'b10;
        for (int i = 0; i < 70000; i++) step();
        s_clr = 1; step();
        s_clr = 0; step(); step();
`endif
        quiet(); step();
        // bounded drain of the scoreboard
        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge HCLK);
        #3;
        if (q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain: %0d predictions left, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
